// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core.
// Sequences ALU, unified memory port, IR, PC and register file through
// FETCH / DECODE / EXEC / MEM / WB. Unsupported instructions and memory
// timeouts enter a sticky TRAP state that only rst_n clears.
// Optional feature: define PERF_COUNTERS_EN to build the cycle and
// retired-instruction counters; otherwise both ports read 0.
module multicycle_control #(
    parameter int unsigned FETCH_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_source,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  ALUOp,
    output logic        reg_write,
    output logic [1:0]  mem_to_reg,
    output logic        trap,
    output logic [2:0]  state,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_retired
);

    localparam int unsigned WAIT_W = 16;
    localparam int unsigned CNT_W  = 32;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Last wait count at which a still-pending access times out.
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (FETCH_TIMEOUT == 0) ? WAIT_W'(0) : WAIT_W'(FETCH_TIMEOUT - 1);

    logic [2:0]        state_q;
    logic [2:0]        next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_legal;

    // Raw strobes before reset gating.
    logic mreq_raw, mwr_raw, irw_raw, pcw_raw, rw_raw;

    logic unused_instr_bits;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign unused_instr_bits = ^{instruction[31:15], instruction[11:7]};

    // Opcode classification; branches only support beq/bne.
    always_comb begin
        is_r     = (opcode == OP_R);
        is_i     = (opcode == OP_I);
        is_ld    = (opcode == OP_LOAD);
        is_st    = (opcode == OP_STORE);
        is_br    = (opcode == OP_BR) && (funct3[2:1] == 2'b00);
        is_jal   = (opcode == OP_JAL);
        is_legal = is_r | is_i | is_ld | is_st | is_br | is_jal;
    end

    assign timeout_hit = (FETCH_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= next_state;
    end

    // Memory wait counter: counts cycles spent in FETCH/MEM, clears on any state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (next_state != state_q) begin
            wait_cnt <= '0;
        end else if ((state_q == S_FETCH) || (state_q == S_MEM)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Next-state and control decode.
    always_comb begin
        next_state = state_q;
        mreq_raw   = 1'b0;
        mwr_raw    = 1'b0;
        irw_raw    = 1'b0;
        pcw_raw    = 1'b0;
        rw_raw     = 1'b0;
        i_or_d     = 1'b0;
        pc_source  = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        ALUOp      = 2'b00;
        mem_to_reg = 2'b00;
        trap       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mreq_raw  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    irw_raw    = 1'b1;
                    pcw_raw    = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b10;
                next_state = is_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (is_r) begin
                    alu_src_a  = 2'b01;
                    ALUOp      = 2'b10;
                    next_state = S_WB;
                end else if (is_i) begin
                    alu_src_a  = 2'b01;
                    alu_src_b  = 2'b10;
                    ALUOp      = 2'b10;
                    next_state = S_WB;
                end else if (is_ld || is_st) begin
                    alu_src_a  = 2'b01;
                    alu_src_b  = 2'b10;
                    next_state = S_MEM;
                end else if (is_br) begin
                    alu_src_a  = 2'b01;
                    ALUOp      = 2'b01;
                    pc_source  = 2'b01;
                    pcw_raw    = funct3[0] ? ~zero : zero;
                    next_state = S_FETCH;
                end else if (is_jal) begin
                    pc_source  = 2'b01;
                    pcw_raw    = 1'b1;
                    rw_raw     = 1'b1;
                    mem_to_reg = 2'b10;
                    next_state = S_FETCH;
                end else begin
                    next_state = S_TRAP;
                end
            end
            S_MEM: begin
                mreq_raw = 1'b1;
                i_or_d   = 1'b1;
                mwr_raw  = is_st;
                if (mem_ready) begin
                    next_state = is_st ? S_FETCH : S_WB;
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                end
            end
            S_WB: begin
                rw_raw     = 1'b1;
                mem_to_reg = is_ld ? 2'b01 : 2'b00;
                next_state = S_FETCH;
            end
            S_TRAP: begin
                trap       = 1'b1;
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_TRAP;
            end
        endcase
    end

    // Reset kills any in-flight access and write strobe immediately.
    assign mem_req   = mreq_raw & rst_n;
    assign mem_write = mwr_raw  & rst_n;
    assign ir_write  = irw_raw  & rst_n;
    assign pc_write  = pcw_raw  & rst_n;
    assign reg_write = rw_raw   & rst_n;
    assign state     = state_q;

`ifdef PERF_COUNTERS_EN
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ret_q;

    // Performance counters, frozen once trapped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else if (state_q != S_TRAP) begin
            cyc_q <= cyc_q + CNT_W'(1);
            if ((next_state == S_FETCH) &&
                ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB))) begin
                ret_q <= ret_q + CNT_W'(1);
            end
        end
    end

    assign cycle_count   = cyc_q;
    assign instr_retired = ret_q;
`else
    assign cycle_count   = '0;
    assign instr_retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vector table through a scoreboard
// queue, plus hand sequences for reset, trap, counters and timeout.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n, zero, mem_ready;
    logic [31:0] instruction;
    logic        mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write, trap;
    logic [1:0]  pc_source, alu_src_a, alu_src_b, ALUOp, mem_to_reg;
    logic [2:0]  state;
    logic [31:0] cycle_count, instr_retired;

    logic        rst_n_to, mem_ready_to;
    logic        to_mem_req, to_mem_write, to_i_or_d, to_ir_write, to_pc_write, to_reg_write, to_trap;
    logic [1:0]  to_pc_source, to_alu_src_a, to_alu_src_b, to_aluop, to_mem_to_reg;
    logic [2:0]  to_state;
    logic [31:0] to_cycle_count, to_instr_retired;
    logic        unused_to;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ALUOp(ALUOp), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .trap(trap), .state(state), .cycle_count(cycle_count),
        .instr_retired(instr_retired)
    );

    multicycle_control #(.FETCH_TIMEOUT(8)) dut_to (
        .clk(clk), .rst_n(rst_n_to), .instruction(32'h002081B3), .zero(1'b0),
        .mem_ready(mem_ready_to), .mem_req(to_mem_req), .mem_write(to_mem_write),
        .i_or_d(to_i_or_d), .ir_write(to_ir_write), .pc_write(to_pc_write),
        .pc_source(to_pc_source), .alu_src_a(to_alu_src_a), .alu_src_b(to_alu_src_b),
        .ALUOp(to_aluop), .reg_write(to_reg_write), .mem_to_reg(to_mem_to_reg),
        .trap(to_trap), .state(to_state), .cycle_count(to_cycle_count),
        .instr_retired(to_instr_retired)
    );

    assign unused_to = ^{to_mem_req, to_mem_write, to_i_or_d, to_ir_write, to_pc_write,
                         to_reg_write, to_pc_source, to_alu_src_a, to_alu_src_b, to_aluop,
                         to_mem_to_reg, to_cycle_count, to_instr_retired};

    // {state, mem_req, mem_write, i_or_d, ir_write, pc_write, pc_source,
    //  alu_src_a, alu_src_b, ALUOp, reg_write, mem_to_reg, trap}
    logic [19:0] act;
    assign act = {state, mem_req, mem_write, i_or_d, ir_write, pc_write, pc_source,
                  alu_src_a, alu_src_b, ALUOp, reg_write, mem_to_reg, trap};

    localparam logic [19:0] F0  = 20'b000_1_0_0_0_0_00_00_01_00_0_00_0;
    localparam logic [19:0] F1  = 20'b000_1_0_0_1_1_00_00_01_00_0_00_0;
    localparam logic [19:0] DEC = 20'b001_0_0_0_0_0_00_10_10_00_0_00_0;
    localparam logic [19:0] ER  = 20'b010_0_0_0_0_0_00_01_00_10_0_00_0;
    localparam logic [19:0] EI  = 20'b010_0_0_0_0_0_00_01_10_10_0_00_0;
    localparam logic [19:0] ELS = 20'b010_0_0_0_0_0_00_01_10_00_0_00_0;
    localparam logic [19:0] EB0 = 20'b010_0_0_0_0_0_01_01_00_01_0_00_0;
    localparam logic [19:0] EB1 = 20'b010_0_0_0_0_1_01_01_00_01_0_00_0;
    localparam logic [19:0] EJ  = 20'b010_0_0_0_0_1_01_00_00_00_1_10_0;
    localparam logic [19:0] ML  = 20'b011_1_0_1_0_0_00_00_00_00_0_00_0;
    localparam logic [19:0] MS  = 20'b011_1_1_1_0_0_00_00_00_00_0_00_0;
    localparam logic [19:0] WL  = 20'b100_0_0_0_0_0_00_00_00_00_1_01_0;
    localparam logic [19:0] WA  = 20'b100_0_0_0_0_0_00_00_00_00_1_00_0;
    localparam logic [19:0] TR  = 20'b111_0_0_0_0_0_00_00_00_00_0_00_1;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0030A023;
    localparam logic [31:0] I_BEQ  = 32'h00000463;
    localparam logic [31:0] I_BNE  = 32'h00001463;
    localparam logic [31:0] I_BLT3 = 32'h00002463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

`ifdef PERF_COUNTERS_EN
    localparam logic [31:0] EXP_CYC40 = 32'd40;
    localparam logic [31:0] EXP_RET10 = 32'd10;
    localparam logic [31:0] EXP_CYC_TRAP = 32'd2;
`else
    localparam logic [31:0] EXP_CYC40 = 32'd0;
    localparam logic [31:0] EXP_RET10 = 32'd0;
    localparam logic [31:0] EXP_CYC_TRAP = 32'd0;
`endif

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        zero;
        logic        rdy;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    task automatic add(input string n, input logic [31:0] i, input logic z,
                       input logic r, input logic [19:0] e);
        vec_t v;
        v.name = n; v.instr = i; v.zero = z; v.rdy = r; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, end at posedge+1.
    task automatic step(input string n, input logic [31:0] i, input logic z,
                        input logic r, input logic [19:0] e);
        vec_t v;
        vec_t got;
        v.name = n; v.instr = i; v.zero = z; v.rdy = r; v.exp = e;
        instruction = i; zero = z; mem_ready = r;
        sb.push_back(v);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({n, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            chk(got.name, 32'(act), 32'(got.exp));
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; instruction = '0; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        chk("rst_instr_retired", instr_retired, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; rst_n_to = 1'b1; mem_ready_to = 1'b0;
        instruction = '0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        rst_n_to = 1'b0;
        do_reset();

        add("add_f", I_ADD, 0, 1, F1);   add("add_d", I_ADD, 0, 1, DEC);
        add("add_e", I_ADD, 0, 1, ER);   add("add_wb", I_ADD, 0, 1, WA);
        add("addi_fw", I_ADDI, 0, 0, F0); add("addi_f", I_ADDI, 0, 1, F1);
        add("addi_d", I_ADDI, 0, 0, DEC); add("addi_e", I_ADDI, 0, 0, EI);
        add("addi_wb", I_ADDI, 0, 0, WA);
        add("lw_f", I_LW, 0, 1, F1);     add("lw_d", I_LW, 0, 0, DEC);
        add("lw_e", I_LW, 0, 0, ELS);
        for (int k = 0; k < 3; k++) add("lw_mwait", I_LW, 0, 0, ML);
        add("lw_mdone", I_LW, 0, 1, ML); add("lw_wb", I_LW, 0, 0, WL);
        add("sw_f", I_SW, 0, 1, F1);     add("sw_d", I_SW, 0, 0, DEC);
        add("sw_e", I_SW, 0, 0, ELS);    add("sw_m", I_SW, 0, 1, MS);
        add("beq1_f", I_BEQ, 0, 1, F1);  add("beq1_d", I_BEQ, 1, 0, DEC);
        add("beq1_e", I_BEQ, 1, 0, EB1);
        add("beq0_f", I_BEQ, 0, 1, F1);  add("beq0_d", I_BEQ, 0, 0, DEC);
        add("beq0_e", I_BEQ, 0, 0, EB0);
        add("bne1_f", I_BNE, 1, 1, F1);  add("bne1_d", I_BNE, 1, 0, DEC);
        add("bne1_e", I_BNE, 1, 0, EB0);
        add("bne0_f", I_BNE, 0, 1, F1);  add("bne0_d", I_BNE, 0, 0, DEC);
        add("bne0_e", I_BNE, 0, 0, EB1);
        add("jal_f", I_JAL, 0, 1, F1);   add("jal_d", I_JAL, 0, 0, DEC);
        add("jal_e", I_JAL, 0, 0, EJ);
        add("back_fetch", I_ADD, 0, 0, F0);

        foreach (tbl[k]) step(tbl[k].name, tbl[k].instr, tbl[k].zero, tbl[k].rdy, tbl[k].exp);

        // No timeout on the default instance: FETCH waits indefinitely.
        for (int k = 0; k < 20; k++) step("fetch_nowait", I_ADD, 0, 0, F0);

        // Async reset in the middle of a memory access.
        do_reset();
        step("mid_f", I_LW, 0, 1, F1);
        step("mid_d", I_LW, 0, 0, DEC);
        step("mid_e", I_LW, 0, 0, ELS);
        step("mid_m", I_LW, 0, 0, ML);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);

        // Illegal opcode: sticky trap for 100 cycles, counters frozen.
        do_reset();
        step("ill_f", I_ILL, 0, 1, F1);
        step("ill_d", I_ILL, 0, 1, DEC);
        for (int k = 0; k < 100; k++) step("ill_trap", I_ILL, 0, 1, TR);
        chk("trap_cycle_count", cycle_count, EXP_CYC_TRAP);
        chk("trap_instr_retired", instr_retired, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("trap_rst_state", 32'(state), 32'd0);
        chk("trap_rst_trap", 32'(trap), 32'd0);

        // Branch with unsupported funct3 traps.
        do_reset();
        step("blt_f", I_BLT3, 0, 1, F1);
        step("blt_d", I_BLT3, 0, 0, DEC);
        step("blt_trap", I_BLT3, 0, 0, TR);

        // Ten back-to-back adds with an always-ready memory.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step("cnt_f", I_ADD, 0, 1, F1);
            step("cnt_d", I_ADD, 0, 1, DEC);
            step("cnt_e", I_ADD, 0, 1, ER);
            step("cnt_wb", I_ADD, 0, 1, WA);
        end
        chk("cnt_cycle_count", cycle_count, EXP_CYC40);
        chk("cnt_instr_retired", instr_retired, EXP_RET10);
        chk("cnt_state", 32'(state), 32'd0);

        // FETCH_TIMEOUT=8: trap after the eighth unanswered FETCH cycle.
        rst_n_to = 1'b1; mem_ready_to = 1'b0;
        for (int k = 0; k < 7; k++) begin @(posedge clk); #1; end
        chk("to_still_fetch", 32'(to_state), 32'd0);
        @(posedge clk); #1;
        chk("to_trap_state", 32'(to_state), 32'd7);
        chk("to_trap_flag", 32'(to_trap), 32'd1);

        // Ready in the same cycle the count expires: the access completes.
        rst_n_to = 1'b0; #1; rst_n_to = 1'b1;
        for (int k = 0; k < 7; k++) begin @(posedge clk); #1; end
        mem_ready_to = 1'b1;
        @(posedge clk); #1;
        mem_ready_to = 1'b0;
        chk("to_ready_wins", 32'(to_state), 32'd1);
        chk("to_ready_no_trap", 32'(to_trap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
